// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered 9-bit ISA decoder with load-use stall, branch-shadow squash and sticky HALT.
// Latency: an accepted instruction appears on the control outputs 1 cycle after acceptance.
// Backpressure: Stall (combinational) asks fetch to hold the word; HALT stalls until Reset.
// Optional perf counters (InstCnt/StallCnt/FlushCnt) are built when CTRL_PERF_EN is defined.
module ctrl_pipe #(
    parameter int         JW      = 8,
    parameter logic [2:0] LD_BASE = 3'd6,
    parameter logic [2:0] ST_BASE = 3'd7,
    parameter int         SHADOW  = 1,
    parameter int         CW      = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          InstValid,
    input  logic [8:0]    MachCode,
    output logic          Stall,
    output logic [JW-1:0] Jptr,
    output logic [2:0]    Aluop,
    output logic [2:0]    Ra,
    output logic [2:0]    Rb,
    output logic [2:0]    Wd,
    output logic          WenR,
    output logic          WenD,
    output logic          RenD,
    output logic          MemToReg,
    output logic          Jen,
    output logic          Done
`ifdef CTRL_PERF_EN
    ,
    output logic [CW-1:0] InstCnt,
    output logic [CW-1:0] StallCnt,
    output logic [CW-1:0] FlushCnt
`endif
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    typedef struct packed {
        logic [JW-1:0] jptr;
        logic [2:0]    aluop;
        logic [2:0]    ra;
        logic [2:0]    rb;
        logic [2:0]    wd;
        logic          wen_r;
        logic          wen_d;
        logic          ren_d;
        logic          mem_to_reg;
        logic          jen;
        logic          done;
    } ctrl_t;

    state_t     r_state;
    state_t     w_nxt_state;
    logic [1:0] r_cnt;
    logic [1:0] w_nxt_cnt;
    ctrl_t      r_out;
    ctrl_t      w_nxt_out;
    ctrl_t      w_dec;

    logic w_is_done, w_is_br, w_is_st, w_is_ld, w_is_mv, w_is_r;
    logic w_rd_hit, w_hazard, w_accept;

    assign w_is_done = (MachCode == 9'b011111111);
    assign w_is_br   = (MachCode[8:6] == 3'b100);
    assign w_is_st   = (MachCode[8:6] == 3'b101);
    assign w_is_ld   = (MachCode[8:6] == 3'b110);
    assign w_is_mv   = (MachCode[8:6] == 3'b111);
    assign w_is_r    = !MachCode[8] && !w_is_done;

    // Field decode: R-type defaults first, then per-class overrides.
    always_comb begin
        w_dec            = '0;
        w_dec.jptr       = JW'(MachCode[5:0]);
        w_dec.aluop      = MachCode[7:5];
        w_dec.ra         = {1'b0, MachCode[4:3]};
        w_dec.rb         = MachCode[2:0];
        w_dec.wd         = MachCode[2:0];
        w_dec.wen_r      = 1'b1;
        if (w_is_done) begin
            w_dec.done  = 1'b1;
            w_dec.wen_r = 1'b0;
        end else if (w_is_br) begin
            w_dec.jen   = 1'b1;
            w_dec.wen_r = 1'b0;
        end else if (w_is_ld) begin
            w_dec.ren_d      = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.wd         = MachCode[5:3];
            w_dec.ra         = LD_BASE;
        end else if (w_is_st) begin
            w_dec.wen_d = 1'b1;
            w_dec.wen_r = 1'b0;
            w_dec.ra    = ST_BASE;
            w_dec.rb    = MachCode[5:3];
        end else if (w_is_mv) begin
            w_dec.ra = MachCode[5:3];
            w_dec.wd = MachCode[2:0];
        end
    end

    // Registers actually read by the incoming word; base registers count as reads.
    assign w_rd_hit = (w_is_r  && ((w_dec.ra == r_out.wd) || (w_dec.rb == r_out.wd)))
                   || (w_is_st && ((w_dec.ra == r_out.wd) || (w_dec.rb == r_out.wd)))
                   || (w_is_mv &&  (w_dec.ra == r_out.wd))
                   || (w_is_ld &&  (w_dec.ra == r_out.wd));

    // Squashed words in FLUSH never stall, so the hazard is qualified with RUN.
    assign w_hazard = (r_state == S_RUN) && r_out.ren_d && InstValid && w_rd_hit;
    assign Stall    = (r_state == S_HALT) || w_hazard;
    assign w_accept = InstValid && !Stall && (r_state == S_RUN);

    // Next state, shadow counter and next registered controls; bubble by default.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_out   = '0;
        case (r_state)
            S_RUN: begin
                if (w_accept) begin
                    if (w_is_done) begin
                        w_nxt_out.done = 1'b1;
                        w_nxt_state    = S_HALT;
                    end else begin
                        w_nxt_out = w_dec;
                        if (w_is_br && (SHADOW > 0)) begin
                            w_nxt_state = S_FLUSH;
                            w_nxt_cnt   = 2'(SHADOW);
                        end
                    end
                end
            end
            S_FLUSH: begin
                w_nxt_cnt = r_cnt - 2'd1;
                if (r_cnt <= 2'd1) begin
                    w_nxt_state = S_RUN;
                end
            end
            S_HALT: begin
                w_nxt_out.done = 1'b1;
            end
            default: begin
                w_nxt_state = S_RUN;
            end
        endcase
    end

    // State, shadow counter and output register update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
            r_out   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_out   <= w_nxt_out;
        end
    end

    assign Jptr     = r_out.jptr;
    assign Aluop    = r_out.aluop;
    assign Ra       = r_out.ra;
    assign Rb       = r_out.rb;
    assign Wd       = r_out.wd;
    assign WenR     = r_out.wen_r;
    assign WenD     = r_out.wen_d;
    assign RenD     = r_out.ren_d;
    assign MemToReg = r_out.mem_to_reg;
    assign Jen      = r_out.jen;
    assign Done     = r_out.done;

`ifdef CTRL_PERF_EN
    logic [CW-1:0] r_inst_cnt, r_stall_cnt, r_flush_cnt;
    logic          w_squash;

    assign w_squash = (r_state == S_FLUSH) && InstValid;

    // Saturating event counters, frozen while halted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_inst_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (r_state != S_HALT) begin
            if (w_accept && !(&r_inst_cnt))  r_inst_cnt  <= r_inst_cnt + CW'(1);
            if (Stall && !(&r_stall_cnt))    r_stall_cnt <= r_stall_cnt + CW'(1);
            if (w_squash && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CW'(1);
        end
    end

    assign InstCnt  = r_inst_cnt;
    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: table of {inputs, expected Stall, expected registered controls}.
// Each vector is driven on the falling edge; Stall is checked before the rising edge,
// the registered controls 1 time unit after it.
module tb_ctrl_pipe;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       InstValid;
    logic [8:0] MachCode;
    logic       Stall;
    logic [7:0] Jptr;
    logic [2:0] Aluop, Ra, Rb, Wd;
    logic       WenR, WenD, RenD, MemToReg, Jen, Done;
`ifdef CTRL_PERF_EN
    logic [15:0] InstCnt, StallCnt, FlushCnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    ctrl_pipe dut (
        .Clk(Clk), .Reset(Reset), .InstValid(InstValid), .MachCode(MachCode),
        .Stall(Stall), .Jptr(Jptr), .Aluop(Aluop), .Ra(Ra), .Rb(Rb), .Wd(Wd),
        .WenR(WenR), .WenD(WenD), .RenD(RenD), .MemToReg(MemToReg), .Jen(Jen), .Done(Done)
`ifdef CTRL_PERF_EN
        , .InstCnt(InstCnt), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    // en = {WenR, WenD, RenD, MemToReg, Jen, Done}
    typedef struct {
        logic       vld;
        logic [8:0] code;
        logic       stall;
        logic [2:0] aluop, ra, rb, wd;
        logic [7:0] jptr;
        logic [5:0] en;
    } vec_t;

    vec_t tbl[22];

    logic [25:0] w_obs;
    assign w_obs = {Aluop, Ra, Rb, Wd, Jptr, WenR, WenD, RenD, MemToReg, Jen, Done};

    function automatic vec_t mk(input logic vld, input logic [8:0] code, input logic stall,
                                input logic [2:0] aluop, input logic [2:0] ra, input logic [2:0] rb,
                                input logic [2:0] wd, input logic [7:0] jptr, input logic [5:0] en);
        vec_t v;
        v.vld = vld; v.code = code; v.stall = stall;
        v.aluop = aluop; v.ra = ra; v.rb = rb; v.wd = wd; v.jptr = jptr; v.en = en;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge Clk);
        InstValid = v.vld;
        MachCode  = v.code;
        #1;
        chk({nm, "_stall"}, 32'(Stall), 32'(v.stall));
        @(posedge Clk);
        #1;
        chk({nm, "_out"}, 32'(w_obs), 32'({v.aluop, v.ra, v.rb, v.wd, v.jptr, v.en}));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset     = 1'b1;
        InstValid = 1'b1;
        MachCode  = 9'b111_010_101;
        @(posedge Clk);
        @(negedge Clk);
        Reset     = 1'b0;
        InstValid = 1'b0;
        #1;
        chk("reset_out", 32'(w_obs), 32'd0);
        chk("reset_stall", 32'(Stall), 32'd0);
    endtask

    initial begin
        //            vld   code           stl aluop ra    rb    wd    jptr   en
        tbl[0]  = mk(1'b1, 9'b111_010_101, 0, 3'd6, 3'd2, 3'd5, 3'd5, 8'h15, 6'b100000); // move
        tbl[1]  = mk(1'b1, 9'b110_011_000, 0, 3'd4, 3'd6, 3'd0, 3'd3, 8'h18, 6'b101100); // load r3
        tbl[2]  = mk(1'b1, 9'b000_011_001, 1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000000); // R reads r3: stall
        tbl[3]  = mk(1'b1, 9'b000_011_001, 0, 3'd0, 3'd3, 3'd1, 3'd1, 8'h19, 6'b100000); // R issued
        tbl[4]  = mk(1'b1, 9'b100_101_010, 0, 3'd1, 3'd1, 3'd2, 3'd2, 8'h2A, 6'b000010); // branch
        tbl[5]  = mk(1'b1, 9'b111_010_101, 0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000000); // squashed
        tbl[6]  = mk(1'b1, 9'b111_001_011, 0, 3'd6, 3'd1, 3'd3, 3'd3, 8'h0B, 6'b100000); // move issued
        tbl[7]  = mk(1'b1, 9'b110_011_000, 0, 3'd4, 3'd6, 3'd0, 3'd3, 8'h18, 6'b101100); // load r3
        tbl[8]  = mk(1'b1, 9'b100_000_001, 0, 3'd0, 3'd0, 3'd1, 3'd1, 8'h01, 6'b000010); // branch, no reads
        tbl[9]  = mk(1'b1, 9'b101_011_000, 0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000000); // store squashed
        tbl[10] = mk(1'b1, 9'b110_011_000, 0, 3'd4, 3'd6, 3'd0, 3'd3, 8'h18, 6'b101100); // load r3
        tbl[11] = mk(1'b1, 9'b101_011_000, 1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000000); // store Rb=r3: stall
        tbl[12] = mk(1'b1, 9'b101_011_000, 0, 3'd2, 3'd7, 3'd3, 3'd0, 8'h18, 6'b010000); // store issued
        tbl[13] = mk(1'b1, 9'b110_111_000, 0, 3'd5, 3'd6, 3'd0, 3'd7, 8'h38, 6'b101100); // load r7
        tbl[14] = mk(1'b1, 9'b101_000_001, 1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000000); // store base r7: stall
        tbl[15] = mk(1'b1, 9'b101_000_001, 0, 3'd2, 3'd7, 3'd0, 3'd1, 8'h01, 6'b010000); // store issued
        tbl[16] = mk(1'b0, 9'b000_011_001, 0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000000); // idle bubble
        tbl[17] = mk(1'b1, 9'b110_011_000, 0, 3'd4, 3'd6, 3'd0, 3'd3, 8'h18, 6'b101100); // load r3
        tbl[18] = mk(1'b1, 9'b111_010_101, 0, 3'd6, 3'd2, 3'd5, 3'd5, 8'h15, 6'b100000); // move r2: no hazard
        tbl[19] = mk(1'b1, 9'b100_101_010, 0, 3'd1, 3'd1, 3'd2, 3'd2, 8'h2A, 6'b000010); // branch
        tbl[20] = mk(1'b0, 9'b111_010_101, 0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000000); // idle shadow cycle
        tbl[21] = mk(1'b1, 9'b111_001_011, 0, 3'd6, 3'd1, 3'd3, 3'd3, 8'h0B, 6'b100000); // issued

        Reset     = 1'b1;
        InstValid = 1'b0;
        MachCode  = '0;
        do_reset();

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Done -> sticky HALT: stall, inputs ignored, bubble except Done.
        @(negedge Clk);
        InstValid = 1'b1;
        MachCode  = 9'b011111111;
        #1;
        chk("done_stall_pre", 32'(Stall), 32'd0);
        @(posedge Clk);
        #1;
        chk("done_set", 32'(Done), 32'd1);
        chk("done_wenr", 32'(WenR), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            MachCode = (k == 1) ? 9'b100_101_010 : 9'b111_010_101;
            #1;
            chk($sformatf("halt%0d_stall", k), 32'(Stall), 32'd1);
            @(posedge Clk);
            #1;
            chk($sformatf("halt%0d_out", k), 32'(w_obs), 32'd1);
        end

        // Reset leaves HALT; the next word is accepted normally.
        do_reset();
        apply(tbl[0], "post_halt_move");

`ifdef CTRL_PERF_EN
        do_reset();
        chk("perf_inst0", 32'(InstCnt), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            apply(tbl[i], $sformatf("perf_v%0d", i));
        end
        chk("perf_inst", 32'(InstCnt), 32'd4);
        chk("perf_stall", 32'(StallCnt), 32'd1);
        chk("perf_flush", 32'(FlushCnt), 32'd1);
        @(negedge Clk);
        InstValid = 1'b1;
        MachCode  = 9'b011111111;
        repeat (3) @(posedge Clk);
        #1;
        chk("perf_inst_halt", 32'(InstCnt), 32'd5);
        chk("perf_stall_halt", 32'(StallCnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
